// File: rtl/ttl_counter_sync.sv
// Parametrised synchronous up/down counter advanced by rising edges of the Cen strobe.
// Supports arbitrary modulus, clear/load, cascading through RCO->ENT, and a registered wrap pulse.
module ttl_counter_sync #(
  parameter int WIDTH       = 4,
  parameter int MODULO      = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cen,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic             ENT,
  input  logic             ENP,
  input  logic             UpDn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC_pulse
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);

  // Power-up state matches the reset state; last_cen starts high so a held Cen cannot tick.
  logic             last_cen = 1'b1;
  logic [WIDTH-1:0] count    = RST;
  logic             tc_reg   = 1'b0;

  logic             tick;
  logic             at_top;
  logic             at_zero;
  logic             wrap;
  logic             step;
  logic [WIDTH-1:0] next_count;

  always_comb begin
    tick    = Cen & ~last_cen;
    at_top  = (count == TOP);
    at_zero = (count == '0);
    wrap    = UpDn ? at_top : at_zero;
    step    = tick & Clear_bar & Load_bar & ENT & ENP;
  end

  // Out-of-range values never match TOP, so they simply increment until the width wraps to 0.
  always_comb begin
    next_count = count;
    if (tick) begin
      if (!Clear_bar) begin
        next_count = '0;
      end else if (!Load_bar) begin
        next_count = D;
      end else if (ENT && ENP) begin
        if (UpDn) begin
          next_count = at_top ? '0 : count + 1'b1;
        end else begin
          next_count = at_zero ? TOP : count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_cen <= 1'b1;
      count    <= RST;
      tc_reg   <= 1'b0;
    end else begin
      last_cen <= Cen;
      count    <= next_count;
      tc_reg   <= step & wrap;
    end
  end

  assign Q        = count;
  assign RCO      = ENT & wrap;
  assign TC_pulse = tc_reg;

endmodule

// File: tb/tb_ttl_counter_sync.sv
// Scoreboarded bench for ttl_counter_sync: decade, mod-12 and a two-stage mod-256 cascade,
// each compared against an arithmetic counter model.
module tb_ttl_counter_sync;

  typedef struct {
    string name;
    int    q;
    int    tc;
    int    rco;
    int    win;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cen;
  logic       clear_bar;
  logic       load_bar;
  logic       ent;
  logic       enp;
  logic       updn;
  logic [3:0] d;

  logic [3:0] q_a, q_b, q0, q1;
  logic       rco_a, rco_b, rco0, rco1;
  logic       tc_a, tc_b, tc0, tc1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_q[3];
  int   low_wraps = 0;
  int   tc0_count = 0;
  exp_t exp_q[3][$];

  always #5 clk = ~clk;

  ttl_counter_sync #(.WIDTH(4), .MODULO(10), .RESET_VALUE(3)) dut_a (
    .Clk(clk), .Reset(reset), .Cen(cen[0]), .Clear_bar(clear_bar), .Load_bar(load_bar),
    .ENT(ent), .ENP(enp), .UpDn(updn), .D(d), .Q(q_a), .RCO(rco_a), .TC_pulse(tc_a)
  );

  ttl_counter_sync #(.WIDTH(4), .MODULO(12), .RESET_VALUE(0)) dut_b (
    .Clk(clk), .Reset(reset), .Cen(cen[1]), .Clear_bar(clear_bar), .Load_bar(load_bar),
    .ENT(ent), .ENP(enp), .UpDn(updn), .D(d), .Q(q_b), .RCO(rco_b), .TC_pulse(tc_b)
  );

  ttl_counter_sync #(.WIDTH(4), .MODULO(16), .RESET_VALUE(0)) stage0 (
    .Clk(clk), .Reset(reset), .Cen(cen[2]), .Clear_bar(clear_bar), .Load_bar(load_bar),
    .ENT(ent), .ENP(enp), .UpDn(updn), .D(d), .Q(q0), .RCO(rco0), .TC_pulse(tc0)
  );

  ttl_counter_sync #(.WIDTH(4), .MODULO(16), .RESET_VALUE(0)) stage1 (
    .Clk(clk), .Reset(reset), .Cen(cen[2]), .Clear_bar(clear_bar), .Load_bar(load_bar),
    .ENT(rco0), .ENP(enp), .UpDn(updn), .D(d), .Q(q1), .RCO(rco1), .TC_pulse(tc1)
  );

  always @(negedge clk) if (tc0) tc0_count++;

  task automatic check_output(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int obs_q(input int k);
    case (k)
      0:       return int'(q_a);
      1:       return int'(q_b);
      default: return int'({q1, q0});
    endcase
  endfunction

  function automatic int obs_tc(input int k);
    case (k)
      0:       return int'(tc_a);
      1:       return int'(tc_b);
      default: return int'(tc1);
    endcase
  endfunction

  function automatic int obs_rco(input int k);
    case (k)
      0:       return int'(rco_a);
      1:       return int'(rco_b);
      default: return int'(rco1);
    endcase
  endfunction

  // The cascade is modelled as a single 8-bit mod-256 counter loaded with {D,D}.
  task automatic model_step(input int k, input int hold, input string name, output exp_t e);
    int mods[3] = '{10, 12, 256};
    int m    = mods[k];
    int span = (k == 2) ? 256 : 16;
    int v    = m_q[k];
    e.tc = 0;
    if (!clear_bar) v = 0;
    else if (!load_bar) v = (k == 2) ? int'(d) * 17 : int'(d);
    else if (ent && enp) begin
      if (k == 2 && ((updn && v % 16 == 15) || (!updn && v % 16 == 0))) low_wraps++;
      if (updn) begin
        if (v == m - 1) begin v = 0; e.tc = 1; end
        else v = (v + 1) % span;
      end else begin
        if (v == 0) begin v = m - 1; e.tc = 1; end
        else v = v - 1;
      end
    end
    m_q[k] = v;
    e.name = name;
    e.q    = v;
    e.rco  = (ent && (updn ? v == m - 1 : v == 0)) ? 1 : 0;
    e.win  = hold + 3;
  endtask

  // One Cen pulse held high for 'hold' cycles, followed by enough low time to re-arm.
  task automatic apply_stimulus(input int k, input int hold, input string name);
    exp_t e;
    model_step(k, hold, name, e);
    exp_q[k].push_back(e);
    @(negedge clk);
    #1 cen[k] = 1'b1;
    repeat (hold) @(negedge clk);
    #1 cen[k] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Watches for a Cen rise, accumulates TC pulses over the transaction window, then compares.
  task automatic monitor(input int k);
    bit   prev = cen[k];
    exp_t e;
    int   tcs;
    forever begin
      @(negedge clk);
      if (cen[k] && !prev) begin
        if (exp_q[k].size() == 0) begin
          check_output($sformatf("unexpected_txn_%0d", k), 1, 0);
        end else begin
          e   = exp_q[k].pop_front();
          tcs = obs_tc(k);
          repeat (e.win - 1) begin
            @(negedge clk);
            tcs += obs_tc(k);
          end
          check_output({e.name, "_q"}, obs_q(k), e.q);
          check_output({e.name, "_tc"}, tcs, e.tc);
          check_output({e.name, "_rco"}, obs_rco(k), e.rco);
        end
      end
      prev = cen[k];
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; cen = 3'b111; clear_bar = 1'b1; load_bar = 1'b1;
    ent = 1'b1; enp = 1'b1; updn = 1'b1; d = 4'd0;
    m_q = '{3, 0, 0};

    // Cen stays high through reset release: no tick may occur.
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_q_a", int'(q_a), 3);
    check_output("reset_tc_a", int'(tc_a), 0);
    check_output("reset_rco_a", int'(rco_a), 0);
    check_output("reset_q_b", int'(q_b), 0);
    check_output("reset_q_cascade", int'({q1, q0}), 0);
    #1 cen = 3'b000;
    @(negedge clk);
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
    @(negedge clk);

    clear_bar = 1'b0;
    apply_stimulus(0, 1, "decade_clear");
    clear_bar = 1'b1;
    for (int i = 0; i < 12; i++) apply_stimulus(0, 1, $sformatf("decade_up_%0d", i));

    load_bar = 1'b0; d = 4'd1;
    apply_stimulus(1, 2, "mod12_load1");
    load_bar = 1'b1; updn = 1'b0;
    apply_stimulus(1, 1, "mod12_down_a");
    apply_stimulus(1, 1, "mod12_down_b");

    clear_bar = 1'b0; load_bar = 1'b0; d = 4'd5; updn = 1'b1;
    apply_stimulus(0, 1, "prio_clear_load");
    clear_bar = 1'b1; ent = 1'b0;
    apply_stimulus(0, 1, "prio_load_ent0");
    load_bar = 1'b1; ent = 1'b1;
    apply_stimulus(0, 10, "prio_held_cen");

    load_bar = 1'b0; d = 4'd14;
    apply_stimulus(0, 1, "illegal_load14");
    load_bar = 1'b1;
    apply_stimulus(0, 1, "illegal_up_a");
    apply_stimulus(0, 1, "illegal_up_b");

    for (int i = 0; i < 40; i++) begin
      clear_bar = ($urandom_range(0, 9) != 0);
      load_bar  = ($urandom_range(0, 5) != 0);
      ent       = ($urandom_range(0, 4) != 0);
      enp       = ($urandom_range(0, 4) != 0);
      updn      = 1'($urandom_range(0, 1));
      d         = 4'($urandom_range(0, 15));
      apply_stimulus(0, int'($urandom_range(1, 3)), $sformatf("rand_%0d", i));
    end

    clear_bar = 1'b1; load_bar = 1'b1; ent = 1'b1; enp = 1'b1; updn = 1'b1;
    for (int i = 0; i < 300; i++) apply_stimulus(2, 1, $sformatf("cascade_%0d", i));

    for (int i = 0; i < 50 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0; i++)
      @(negedge clk);
    check_output("scoreboard_drain", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    check_output("cascade_final", int'({q1, q0}), 44);
    check_output("cascade_low_wraps", tc0_count, low_wraps);

    // Reset mid-count returns every counter to its reset value on the next edge.
    updn = 1'b0; ent = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    check_output("midreset_q_a", int'(q_a), 3);
    check_output("midreset_q_b", int'(q_b), 0);
    check_output("midreset_q_cascade", int'({q1, q0}), 0);
    check_output("midreset_tc_a", int'(tc_a), 0);
    #1 reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
